// File: rtl/lsu_bus_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
// A request transfers on a rising edge where req_valid && req_ready; once raised,
// req_valid and the request fields hold until that edge, except on a timeout abort.
// rsp_valid is a one-cycle pulse carrying rdata, at the earliest one cycle after accept.
interface lsu_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, we, addr, wdata, wstrb,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata, wstrb,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: turns one load/store per instruction into a single word-aligned
// bus transaction, stalling the core until the access completes or fails.
module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       func3,
    input  logic [31:0]      addr,
    input  logic [31:0]      Wr_mem_data,
    output logic [31:0]      Rd_mem_data,
    output logic             stall,
    output logic             err,
    output logic [1:0]       err_cause,
    output logic [1:0]       dbg_state,
    lsu_bus_if.master        bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q;
    logic [31:0] to_cnt;

    logic        illegal;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;
    logic        timeout_hit;

    // Illegal encodings take priority over misalignment when both apply.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (func3)
            3'b000: ;
            3'b001: misaligned = addr[0];
            3'b010: misaligned = (addr[1:0] != 2'b00);
            3'b100: illegal = mem_write;
            3'b101: begin
                illegal    = mem_write;
                misaligned = addr[0];
            end
            default: illegal = 1'b1;
        endcase
        if (mem_read && mem_write) illegal = 1'b1;
    end

    always_comb begin
        st_wdata = Wr_mem_data;
        st_wstrb = 4'b1111;
        case (func3[1:0])
            2'b00: begin
                st_wdata = {4{Wr_mem_data[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{Wr_mem_data[15:0]}};
                st_wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            default: ;
        endcase
        if (!mem_write) st_wstrb = 4'b0000;
    end

    always_comb begin
        lane_b = bus.rdata[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  ld_data = {24'h0, lane_b};
            3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  ld_data = {16'h0, lane_h};
            default: ld_data = bus.rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt >= TO_LAST);
    assign stall       = ((state == S_IDLE) && (mem_read || mem_write)) ||
                         (state == S_REQ) || (state == S_WAIT);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            is_load_q     <= 1'b0;
            to_cnt        <= 32'h0;
            Rd_mem_data   <= 32'h0;
            err           <= 1'b0;
            err_cause     <= 2'b00;
            bus.req_valid <= 1'b0;
            bus.we        <= 1'b0;
            bus.addr      <= 32'h0;
            bus.wdata     <= 32'h0;
            bus.wstrb     <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        f3_q      <= func3;
                        off_q     <= addr[1:0];
                        is_load_q <= mem_read;
                        if (illegal || misaligned) begin
                            state       <= S_DONE;
                            err         <= 1'b1;
                            err_cause   <= illegal ? 2'b11 : 2'b01;
                            Rd_mem_data <= 32'h0;
                        end else begin
                            state         <= S_REQ;
                            to_cnt        <= 32'h0;
                            bus.req_valid <= 1'b1;
                            bus.we        <= mem_write;
                            bus.addr      <= {addr[31:2], 2'b00};
                            bus.wdata     <= st_wdata;
                            bus.wstrb     <= st_wstrb;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.req_ready) begin
                        bus.req_valid <= 1'b0;
                        to_cnt        <= to_cnt + 32'd1;
                        if (is_load_q) begin
                            state <= S_WAIT;
                        end else begin
                            state       <= S_DONE;
                            err         <= 1'b0;
                            err_cause   <= 2'b00;
                            Rd_mem_data <= 32'h0;
                        end
                    end else if (timeout_hit) begin
                        // Abort is the one case where valid drops without an accept.
                        bus.req_valid <= 1'b0;
                        state         <= S_DONE;
                        err           <= 1'b1;
                        err_cause     <= 2'b10;
                        Rd_mem_data   <= 32'h0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        state       <= S_DONE;
                        err         <= 1'b0;
                        err_cause   <= 2'b00;
                        Rd_mem_data <= ld_data;
                    end else if (timeout_hit) begin
                        state       <= S_DONE;
                        err         <= 1'b1;
                        err_cause   <= 2'b10;
                        Rd_mem_data <= 32'h0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: a vector table of single accesses plus
// hand-written timeout and reset-in-flight sequences.
module tb_lsu_bus_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wr_data, rd_data;
    logic        stall, err;
    logic [1:0]  err_cause, dbg_state;

    logic        t_mem_read, t_mem_write;
    logic [2:0]  t_func3;
    logic [31:0] t_addr, t_wr_data, t_rd_data;
    logic        t_stall, t_err;
    logic [1:0]  t_err_cause, t_dbg_state;

    lsu_bus_if bus_a ();
    lsu_bus_if bus_b ();

    lsu_bus_ctrl dut_a (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .addr(addr), .Wr_mem_data(wr_data), .Rd_mem_data(rd_data),
        .stall(stall), .err(err), .err_cause(err_cause), .dbg_state(dbg_state),
        .bus(bus_a)
    );

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .mem_read(t_mem_read), .mem_write(t_mem_write),
        .func3(t_func3), .addr(t_addr), .Wr_mem_data(t_wr_data), .Rd_mem_data(t_rd_data),
        .stall(t_stall), .err(t_err), .err_cause(t_err_cause), .dbg_state(t_dbg_state),
        .bus(bus_b)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [1:0]  exp_cause;
        int          exp_stall;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;
    logic [34:0] exp_q[$];

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
                                input int dly, input logic eb, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] ews,
                                input logic [31:0] erd, input logic ee, input logic [1:0] ec,
                                input int est);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdt;
        v.delay = dly; v.exp_bus = eb; v.exp_addr = ea; v.exp_wdata = ewd;
        v.exp_wstrb = ews; v.exp_rd = erd; v.exp_err = ee; v.exp_cause = ec;
        v.exp_stall = est;
        return v;
    endfunction

    // Called just after a rising edge with dut_a in IDLE; acts as core and memory.
    task automatic do_access(input vec_t v, input string tag);
        int          req_cyc = 0;
        int          stall_cyc = 0;
        logic        done = 1'b0;
        logic        rsp_pending = 1'b0;
        logic [34:0] exp_res;
        logic [31:0] rd_seen;
        mem_read  = v.rd;
        mem_write = v.wr;
        func3     = v.f3;
        addr      = v.addr;
        wr_data   = v.wdata;
        exp_q.push_back({v.exp_err, v.exp_cause, v.exp_rd});
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            bus_a.rsp_valid = 1'b0;
            if (stall) stall_cyc++;
            if (dbg_state == 2'd3) begin
                done    = 1'b1;
                exp_res = exp_q.pop_front();
                rd_seen = (v.wr && !v.exp_err) ? exp_res[31:0] : rd_data;
                chk({tag, " result"}, {err, err_cause, rd_seen}, exp_res);
                chk({tag, " done_stall"}, {34'h0, stall}, 35'h0);
            end else begin
                if (rsp_pending) begin
                    bus_a.rsp_valid = 1'b1;
                    bus_a.rdata     = v.rdata;
                    rsp_pending     = 1'b0;
                end
                if (bus_a.req_valid) begin
                    req_cyc++;
                    chk({tag, " addr"}, {3'b0, bus_a.addr}, {3'b0, v.exp_addr});
                    chk({tag, " we"}, {34'h0, bus_a.we}, {34'h0, v.wr});
                    chk({tag, " wstrb"}, {31'h0, bus_a.wstrb}, {31'h0, v.exp_wstrb});
                    if (v.wr) chk({tag, " wdata"}, {3'b0, bus_a.wdata}, {3'b0, v.exp_wdata});
                    bus_a.req_ready = (req_cyc > v.delay);
                    if (bus_a.req_ready && v.rd) rsp_pending = 1'b1;
                end else begin
                    bus_a.req_ready = 1'b0;
                end
            end
        end
        if (!done) chk({tag, " reached_done"}, 35'h0, 35'h1);
        chk({tag, " stall_cycles"}, 35'(stall_cyc), 35'(v.exp_stall));
        chk({tag, " req_cycles"}, 35'(req_cyc), v.exp_bus ? 35'(v.delay + 1) : 35'h0);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int   vcnt;
        logic done;
        vecs[0]  = mk(0, 1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 1, 32'h1000, 32'hA5A5A5A5, 4'b1000, 32'h0, 0, 2'b00, 2);
        vecs[1]  = mk(1, 0, 3'b000, 32'h2001, 32'h0, 32'h00008000, 0, 1, 32'h2000, 32'h0, 4'b0000, 32'hFFFFFF80, 0, 2'b00, 3);
        vecs[2]  = mk(1, 0, 3'b100, 32'h2001, 32'h0, 32'h00008000, 0, 1, 32'h2000, 32'h0, 4'b0000, 32'h00000080, 0, 2'b00, 3);
        vecs[3]  = mk(1, 0, 3'b001, 32'h2002, 32'h0, 32'h80010000, 5, 1, 32'h2000, 32'h0, 4'b0000, 32'hFFFF8001, 0, 2'b00, 8);
        vecs[4]  = mk(1, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 2'b01, 1);
        vecs[5]  = mk(1, 0, 3'b011, 32'h3000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 2'b11, 1);
        vecs[6]  = mk(0, 1, 3'b001, 32'h1002, 32'h1234BEEF, 32'h0, 0, 1, 32'h1000, 32'hBEEFBEEF, 4'b1100, 32'h0, 0, 2'b00, 2);
        vecs[7]  = mk(1, 0, 3'b101, 32'h2000, 32'h0, 32'h1234ABCD, 0, 1, 32'h2000, 32'h0, 4'b0000, 32'h0000ABCD, 0, 2'b00, 3);
        vecs[8]  = mk(1, 0, 3'b010, 32'h2004, 32'h0, 32'hDEADBEEF, 2, 1, 32'h2004, 32'h0, 4'b0000, 32'hDEADBEEF, 0, 2'b00, 5);
        vecs[9]  = mk(0, 1, 3'b100, 32'h1000, 32'h55, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 2'b11, 1);
        vecs[10] = mk(1, 1, 3'b010, 32'h0010, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 2'b11, 1);
        vecs[11] = mk(0, 1, 3'b001, 32'h1001, 32'hFFFF, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 2'b01, 1);
        vecs[12] = mk(1, 0, 3'b000, 32'h2003, 32'h0, 32'h7F000000, 0, 1, 32'h2000, 32'h0, 4'b0000, 32'h0000007F, 0, 2'b00, 3);
        vecs[13] = mk(0, 1, 3'b000, 32'h1001, 32'hFFFFFF3C, 32'h0, 0, 1, 32'h1000, 32'h3C3C3C3C, 4'b0010, 32'h0, 0, 2'b00, 2);
        vecs[14] = mk(1, 0, 3'b001, 32'h2000, 32'h0, 32'h00017FFE, 0, 1, 32'h2000, 32'h0, 4'b0000, 32'h00007FFE, 0, 2'b00, 3);
        vecs[15] = mk(0, 1, 3'b010, 32'h4008, 32'hCAFEF00D, 32'h0, 0, 1, 32'h4008, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 2'b00, 2);
        vecs[16] = mk(1, 0, 3'b101, 32'h2003, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 2'b01, 1);

        // Clock/reset
        rst = 1'b1;
        mem_read = 0; mem_write = 0; func3 = 0; addr = 0; wr_data = 0;
        t_mem_read = 0; t_mem_write = 0; t_func3 = 0; t_addr = 0; t_wr_data = 0;
        bus_a.req_ready = 0; bus_a.rsp_valid = 0; bus_a.rdata = 0;
        bus_b.req_ready = 0; bus_b.rsp_valid = 0; bus_b.rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset state_a", {33'h0, dbg_state}, 35'h0);
        chk("reset outs_a", {stall, bus_a.req_valid, err, err_cause, rd_data}, 35'h0);
        chk("reset outs_b", {t_stall, bus_b.req_valid, t_err, t_err_cause, t_rd_data}, 35'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) do_access(vecs[i], $sformatf("vec%0d", i));

        // Timeout: ready held low on the 4-cycle instance.
        t_mem_read = 1'b1; t_func3 = 3'b010; t_addr = 32'h100;
        vcnt = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            @(negedge clk);
            if (bus_b.req_valid) vcnt++;
            if (t_dbg_state == 2'd3) done = 1'b1;
        end
        chk("to reached_done", {34'h0, done}, 35'h1);
        chk("to valid_cycles", 35'(vcnt), 35'd4);
        chk("to result", {t_err, t_err_cause, t_rd_data}, {1'b1, 2'b10, 32'h0});
        chk("to valid_dropped", {34'h0, bus_b.req_valid}, 35'h0);
        @(posedge clk);
        #1;
        t_mem_read = 1'b0;
        @(negedge clk);
        bus_b.rsp_valid = 1'b1;
        bus_b.rdata = 32'h12345678;
        @(negedge clk);
        bus_b.rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("to late_rsp_state", {33'h0, t_dbg_state}, 35'h0);
            chk("to late_rsp_outs", {t_stall, bus_b.req_valid, t_err, t_err_cause, t_rd_data},
                {1'b0, 1'b0, 1'b1, 2'b10, 32'h0});
            @(negedge clk);
        end

        // Reset while a load waits for its response.
        @(posedge clk);
        #1;
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h2000;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (dbg_state == 2'd2) done = 1'b1;
            else bus_a.req_ready = bus_a.req_valid;
        end
        chk("rst reached_wait", {34'h0, done}, 35'h1);
        rst = 1'b1;
        mem_read = 1'b0;
        bus_a.req_ready = 1'b0;
        @(negedge clk);
        chk("rst state", {33'h0, dbg_state}, 35'h0);
        chk("rst outs", {stall, bus_a.req_valid, err, err_cause, rd_data}, 35'h0);
        rst = 1'b0;
        bus_a.rsp_valid = 1'b1;
        bus_a.rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_a.rsp_valid = 1'b0;
        chk("rst late_rsp", {stall, bus_a.req_valid, err, err_cause, rd_data}, 35'h0);
        chk("rst late_state", {33'h0, dbg_state}, 35'h0);
        @(posedge clk);
        #1;
        do_access(mk(0, 1, 3'b010, 32'h4000, 32'h11223344, 32'h0, 0, 1, 32'h4000, 32'h11223344,
                     4'b1111, 32'h0, 0, 2'b00, 2), "post_rst_sw");

        if (exp_q.size() != 0) chk("scoreboard drained", 35'(exp_q.size()), 35'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_bus_ctrl.md
# lsu_bus_ctrl

Load/store unit sitting directly downstream of the single-cycle datapath: consumes its ALU result (address), store data, func3 and the memory read/write strobes, and turns each access into one word-aligned bus transaction on a valid/ready data-memory port. Performs byte-lane steering, write-strobe generation, load sign/zero extension and alignment checks. Holds the core with a stall signal for the duration of the access, then returns load data on Rd_mem_data.

## Interface
- TIMEOUT_CYCLES, 64: max cycles spent in REQ+WAIT before abort; 0 disables timeout.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store.
- func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010).
- addr  in  32  byte address (ALU_result).
- Wr_mem_data  in  32  store data, right-aligned.
- Rd_mem_data  out  32  extended load data, valid in DONE.
- stall  out  1  hold PC/register write while high.
- err  out  1  access failed, valid in DONE.
- err_cause  out  2  01 misaligned, 10 timeout, 11 illegal (bad func3 or read&write).
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted when valid&ready.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-steered store data.
- bus_wstrb  out  4  byte enables (0000 on reads).
- bus_rsp_valid  in  1  read data valid, single-cycle pulse.
- bus_rdata  in  32  read word.

## Operation
- States IDLE, REQ, WAIT, DONE. Reset: IDLE; all outputs 0 (stall=0, bus_req_valid=0, Rd_mem_data=0, err=0, err_cause=00).
- IDLE: on mem_read|mem_write, register addr, func3, data, op. Legal and aligned -> REQ. Misaligned (H with addr[0]=1, W with addr[1:0]!=0), illegal func3 (011/110/111, or 100/101 on store), or mem_read&mem_write -> DONE with err=1 and matching cause, no bus activity.
- REQ: bus_req_valid=1; bus_we/addr/wdata/wstrb held stable from registered copies until accept. On accept: store -> DONE; load -> WAIT.
- WAIT: on bus_rsp_valid, extract lane by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU/W) into Rd_mem_data register -> DONE.
- DONE: one cycle, stall=0, Rd_mem_data/err/err_cause presented; requests ignored; -> IDLE. Rd_mem_data/err hold until next DONE overwrites (0 on error).
- Store steering: SB wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=0011<<{addr[1],0}; SW wdata=d, wstrb=1111.
- Timeout: counter cleared on REQ entry, counts each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES without completion -> DONE, err=1, cause 10, bus_req_valid dropped (only permitted valid withdrawal).
- bus_rsp_valid outside WAIT is ignored; a late response after timeout is discarded.

## Timing
- stall = combinational (IDLE & (mem_read|mem_write)) | REQ | WAIT; low in DONE and idle IDLE.
- Store, ready already high: IDLE, REQ(accept), DONE = 3 cycles, stall high 2.
- Load, ready high, response one cycle after accept: IDLE, REQ, WAIT, DONE = 4 cycles, stall high 3.
- Error in IDLE: IDLE, DONE = 2 cycles.
- Response earliest the cycle after accept; response in accept cycle is not supported.
- rst mid-access: next edge to IDLE, bus_req_valid=0, counter cleared, outputs reset; pending bus response dropped.

## Test plan
- SB addr=0x1003 data=0x000000A5, ready=1 -> bus_addr=0x1000, wdata=0xA5A5A5A5, wstrb=1000, we=1, stall high 2 cycles, err=0.
- LB addr=0x2001, rdata=0x0000_8000 one cycle after accept -> Rd_mem_data=0xFFFFFF80; same with LBU -> 0x00000080; stall high 3 cycles.
- LH addr=0x2002, ready delayed 5 cycles, rdata=0x8001_0000 -> request fields stable all 5 cycles, Rd_mem_data=0xFFFF8001.
- LW addr=0x3002 -> no bus_req_valid, DONE next cycle with err=1, err_cause=01; func3=011 -> cause 11.
- TIMEOUT_CYCLES=4, ready held 0 -> bus_req_valid for 4 cycles, then DONE err=1 cause 10; later rsp pulse ignored.
- rst asserted while in WAIT -> next cycle IDLE, stall=0, bus_req_valid=0; subsequent SW 0x4000 completes normally.
